// File: rtl/pwm_dt_pkg.sv
// Shared definitions for the dead-time gate-drive stage.
//   - register word addresses of the Avalon-MM slave
//   - per-channel FSM state encoding (dt_state_t)
//   - default dead-time counter width
package pwm_dt_pkg;

    localparam int DT_W_DEFAULT = 8;

    localparam logic [3:0] ADDR_CTRL      = 4'h0;
    localparam logic [3:0] ADDR_DEADTIME  = 4'h1;
    localparam logic [3:0] ADDR_STATUS    = 4'h2;
    localparam logic [3:0] ADDR_FAULT_CNT = 4'h3;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_LO_ON      = 3'd1,
        ST_DEAD_TO_HI = 3'd2,
        ST_HI_ON      = 3'd3,
        ST_DEAD_TO_LO = 3'd4
    } dt_state_t;

endpackage

// File: rtl/deadtime_channel.sv
// One complementary gate-drive channel: turns a single PWM level into a
// high-side / low-side enable pair separated by a programmable dead interval.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : channel enable (0 forces OFF)
//   fault_i        : fault latch (1 forces OFF)
//   pwm_i          : registered PWM level
//   dead_i         : dead cycles D (0 behaves as 1), sampled only on a counter load
//   hi_o, lo_o     : gate enables, decoded from the state register only
//   state_o        : current FSM state, for probing
module deadtime_channel
    import pwm_dt_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            en_i,
    input  logic            fault_i,
    input  logic            pwm_i,
    input  logic [DT_W-1:0] dead_i,
    output logic            hi_o,
    output logic            lo_o,
    output dt_state_t       state_o
);

    dt_state_t       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic [DT_W-1:0] load_val;

    // A zero dead time would let both sides overlap, so it is clamped to one cycle.
    assign load_val = (dead_i == '0) ? DT_W'(1) : dead_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i || fault_i) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = pwm_i ? ST_DEAD_TO_HI : ST_DEAD_TO_LO;
                    cnt_d   = load_val;
                end
                ST_LO_ON: begin
                    if (pwm_i) begin
                        state_d = ST_DEAD_TO_HI;
                        cnt_d   = load_val;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_i) begin
                        state_d = ST_DEAD_TO_LO;
                        cnt_d   = load_val;
                    end
                end
                // The abort test comes first: if the PWM level has already
                // gone back, the pulse is swallowed even on the last dead cycle.
                ST_DEAD_TO_HI: begin
                    if (!pwm_i) begin
                        state_d = ST_LO_ON;
                    end else if (cnt_q == DT_W'(1)) begin
                        state_d = ST_HI_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                ST_DEAD_TO_LO: begin
                    if (pwm_i) begin
                        state_d = ST_HI_ON;
                    end else if (cnt_q == DT_W'(1)) begin
                        state_d = ST_LO_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Each output is true in exactly one state, so hi_o & lo_o cannot both be 1.
    assign hi_o    = (state_q == ST_HI_ON);
    assign lo_o    = (state_q == ST_LO_ON);
    assign state_o = state_q;

endmodule

// File: rtl/avalon_mm_pwm_deadtime.sv
// Dead-time gate-drive stage with latched fault shutdown and an Avalon-MM
// 16-bit configuration slave.
//   clk, reset          : single clock, synchronous active-high reset
//   address, read,
//   readdata, write,
//   writedata           : Avalon-MM slave (CTRL, DEADTIME, STATUS, FAULT_CNT)
//   pwm_in[NCH]         : PWM levels from the PWM controller
//   fault               : asynchronous active-high external fault
//   out_hi/out_lo[NCH]  : complementary gate enables
//   fault_irq           : fault latch
//
// Bus handshake: read and write are single-cycle strobes with no waitrequest;
// a write takes effect at the edge it is sampled on, readdata carries the
// addressed register one cycle after read (value before any same-cycle write)
// and is 0 in every other cycle.
module avalon_mm_pwm_deadtime
    import pwm_dt_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     address,
    input  logic           read,
    output logic [15:0]    readdata,
    input  logic           write,
    input  logic [15:0]    writedata,
    input  logic [NCH-1:0] pwm_in,
    input  logic           fault,
    output logic [NCH-1:0] out_hi,
    output logic [NCH-1:0] out_lo,
    output logic           fault_irq
);

    logic [NCH-1:0]  pwm_q;
    logic            fault_meta_q, fault_s_q;
    logic            fault_latch_q, fault_latch_d;
    logic [15:0]     fault_cnt_q, fault_cnt_d;
    logic [NCH-1:0]  ctrl_q, ctrl_d;
    logic [DT_W-1:0] dt_q, dt_d;
    logic [15:0]     readdata_q, readdata_d;
    logic [15:0]     rd_mux;
    logic            clear_req;
    logic            wdata_unused;

    // Per-channel FSM states, kept visible for probes and bound checkers.
    dt_state_t       dbg_state_unused [NCH];

    assign wdata_unused = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q         <= '0;
            fault_meta_q  <= 1'b0;
            fault_s_q     <= 1'b0;
            fault_latch_q <= 1'b0;
            fault_cnt_q   <= '0;
            ctrl_q        <= '0;
            dt_q          <= '1;
            readdata_q    <= '0;
        end else begin
            pwm_q         <= pwm_in;
            fault_meta_q  <= fault;
            fault_s_q     <= fault_meta_q;
            fault_latch_q <= fault_latch_d;
            fault_cnt_q   <= fault_cnt_d;
            ctrl_q        <= ctrl_d;
            dt_q          <= dt_d;
            readdata_q    <= readdata_d;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        dt_d   = dt_q;
        if (write && (address == ADDR_CTRL)) begin
            ctrl_d = writedata[NCH-1:0];
        end
        if (write && (address == ADDR_DEADTIME)) begin
            dt_d = writedata[DT_W-1:0];
        end
    end

    // A live fault keeps the latch set: it wins over a clear in the same cycle
    // and makes a clear written while the fault is still present a no-op.
    assign clear_req = write && (address == ADDR_STATUS) && writedata[0];

    always_comb begin
        fault_latch_d = fault_latch_q;
        if (fault_s_q) begin
            fault_latch_d = 1'b1;
        end else if (clear_req) begin
            fault_latch_d = 1'b0;
        end
    end

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (!fault_latch_q && fault_latch_d && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:      rd_mux[NCH-1:0]  = ctrl_q;
            ADDR_DEADTIME:  rd_mux[DT_W-1:0] = dt_q;
            ADDR_STATUS: begin
                rd_mux[0]       = fault_latch_q;
                rd_mux[1]       = fault_s_q;
                rd_mux[4 +: NCH] = pwm_q;
            end
            ADDR_FAULT_CNT: rd_mux = fault_cnt_q;
            default:        rd_mux = '0;
        endcase
    end

    assign readdata_d = read ? rd_mux : 16'h0000;
    assign readdata   = readdata_q;
    assign fault_irq  = fault_latch_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        deadtime_channel #(
            .DT_W (DT_W)
        ) u_ch (
            .clk_i   (clk),
            .reset_i (reset),
            .en_i    (ctrl_q[g]),
            .fault_i (fault_latch_q),
            .pwm_i   (pwm_q[g]),
            .dead_i  (dt_q),
            .hi_o    (out_hi[g]),
            .lo_o    (out_lo[g]),
            .state_o (dbg_state_unused[g])
        );
    end

endmodule
